// File: rtl/fetch_pc_if.sv
// Fetch-sequencer bus: program control from the host side, ROM address/data, and status.
interface fetch_pc_if #(
    parameter int PC_W  = 12,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stall;
    logic             branch_taken;
    logic [PC_W-1:0]  branch_target;
    logic [8:0]       instruction;
    logic [PC_W-1:0]  instr_ROM_ctr;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output start, stall, branch_taken, branch_target, instruction,
        input  instr_ROM_ctr, running, done, retired_cnt
    );

    modport slave (
        input  start, stall, branch_taken, branch_target, instruction,
        output instr_ROM_ctr, running, done, retired_cnt
    );
endinterface

// File: rtl/fetch_pc.sv
// Program counter and fetch sequencer feeding the control decoder.
//
// state | meaning
// IDLE  | out of reset, waiting for start; PC held
// RUN   | fetching one instruction per unstalled cycle
// DONE  | halt word seen; PC parked on the halt address until next start
module fetch_pc #(
    parameter int              PC_W       = 12,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter logic [8:0]      HALT_INSTR = 9'h1FF,
    parameter int              CNT_W      = 16
) (
    input logic        clk,
    input logic        reset_n,
    fetch_pc_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Halt outranks a same-cycle branch so the PC parks on the halt word.
                if (!bus.stall) begin
                    if (bus.instruction == HALT_INSTR) begin
                        state_d = DONE;
                    end else begin
                        pc_d = bus.branch_taken ? bus.branch_target : pc_q + PC_W'(1);
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.instr_ROM_ctr = pc_q;
    assign bus.retired_cnt   = cnt_q;
    assign bus.running       = (state_q == RUN);
    assign bus.done          = (state_q == DONE);
endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc: a reference model predicts each edge, DUT outputs are compared after it.
module tb_fetch_pc;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rst_s_n = 1'b0;
    always #5 clk = ~clk;

    fetch_pc_if #(.PC_W(12), .CNT_W(16)) bif ();
    fetch_pc_if #(.PC_W(4),  .CNT_W(3))  sif ();

    fetch_pc #(.PC_W(12), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bif)
    );
    fetch_pc #(.PC_W(4), .CNT_W(3)) u_small (
        .clk(clk), .reset_n(rst_s_n), .bus(sif)
    );

    logic [8:0] rom [0:4095];
    assign bif.instruction = rom[bif.instr_ROM_ctr];
    assign sif.instruction = 9'h000;

    typedef struct {
        int          st;
        logic [31:0] pc;
        logic [31:0] cnt;
    } mdl_t;

    mdl_t mb, ms;
    mdl_t qb[$];
    mdl_t qs[$];
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t nxt(input mdl_t c, input logic rn, input logic st, input logic stl,
                                 input logic br, input logic [31:0] tgt, input logic [8:0] ins,
                                 input logic [31:0] pc_mask, input logic [31:0] cnt_max);
        mdl_t n;
        n = c;
        if (!rn) begin
            n.st = 0; n.pc = 0; n.cnt = 0;
        end else if (c.st == 0 || c.st == 2) begin
            if (st) begin
                n.st = 1; n.pc = 0; n.cnt = 0;
            end
        end else if (!stl) begin
            if (ins == 9'h1FF) begin
                n.st = 2;
            end else begin
                n.pc = br ? (tgt & pc_mask) : ((c.pc + 1) & pc_mask);
                if (c.cnt < cnt_max) n.cnt = c.cnt + 1;
            end
        end
        return n;
    endfunction

    task automatic step();
        mdl_t e;
        e = nxt(mb, reset_n, bif.start, bif.stall, bif.branch_taken, 32'(bif.branch_target),
                rom[mb.pc[11:0]], 32'hFFF, 32'hFFFF);
        mb = e;
        qb.push_back(e);
        @(posedge clk);
        #1;
        e = qb.pop_front();
        check_eq("pc", 32'(bif.instr_ROM_ctr), e.pc);
        check_eq("cnt", 32'(bif.retired_cnt), e.cnt);
        check_eq("running", 32'(bif.running), 32'(e.st == 1));
        check_eq("done", 32'(bif.done), 32'(e.st == 2));
    endtask

    task automatic step_s();
        mdl_t e;
        e = nxt(ms, rst_s_n, sif.start, 1'b0, 1'b0, 32'h0, 9'h000, 32'hF, 32'h7);
        ms = e;
        qs.push_back(e);
        @(posedge clk);
        #1;
        e = qs.pop_front();
        check_eq("s_pc", 32'(sif.instr_ROM_ctr), e.pc);
        check_eq("s_cnt", 32'(sif.retired_cnt), e.cnt);
        check_eq("s_running", 32'(sif.running), 32'(e.st == 1));
    endtask

    task automatic pulse_start();
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
    endtask

    task automatic run_to_pc(input logic [11:0] target, input string tag);
        for (int i = 0; i < 32 && bif.instr_ROM_ctr != target; i++) step();
        check_eq(tag, 32'(bif.instr_ROM_ctr), 32'(target));
    endtask

    task automatic run_to_done(input string tag);
        for (int i = 0; i < 32 && !bif.done; i++) step();
        check_eq(tag, 32'(bif.done), 32'd1);
    endtask

    initial begin
        mb = '{st: 0, pc: 0, cnt: 0};
        ms = '{st: 0, pc: 0, cnt: 0};
        for (int i = 0; i < 4096; i++) rom[i] = 9'(i % 256);
        rom[4] = 9'h1FF;
        rom[5] = 9'h1FF;
        bif.start = 1'b0; bif.stall = 1'b0; bif.branch_taken = 1'b0; bif.branch_target = '0;
        sif.start = 1'b0; sif.stall = 1'b0; sif.branch_taken = 1'b0; sif.branch_target = '0;

        // reset state
        step(); step();
        reset_n = 1'b1;
        step();
        check_eq("rst_pc", 32'(bif.instr_ROM_ctr), 32'd0);
        check_eq("rst_running", 32'(bif.running), 32'd0);

        // straight-line run to halt at address 4
        pulse_start();
        run_to_done("halt4_done");
        check_eq("halt4_pc", 32'(bif.instr_ROM_ctr), 32'd4);
        check_eq("halt4_cnt", 32'(bif.retired_cnt), 32'd4);
        check_eq("halt4_running", 32'(bif.running), 32'd0);
        bif.stall = 1'b1; bif.branch_taken = 1'b1; bif.branch_target = 12'h123;
        step(); step();
        bif.stall = 1'b0; bif.branch_taken = 1'b0;
        check_eq("done_ignores_br", 32'(bif.instr_ROM_ctr), 32'd4);

        // restart from DONE, branch, self-loop, branch onto halt
        rom[4] = 9'h004;
        pulse_start();
        check_eq("restart_done", 32'(bif.done), 32'd0);
        check_eq("restart_running", 32'(bif.running), 32'd1);
        check_eq("restart_cnt", 32'(bif.retired_cnt), 32'd0);
        run_to_pc(12'd2, "reach_pc2");
        bif.branch_taken = 1'b1; bif.branch_target = 12'h040;
        step();
        check_eq("br_pc", 32'(bif.instr_ROM_ctr), 32'h040);
        check_eq("br_cnt", 32'(bif.retired_cnt), 32'd3);
        step(); step();
        check_eq("selfloop_pc", 32'(bif.instr_ROM_ctr), 32'h040);
        check_eq("selfloop_cnt", 32'(bif.retired_cnt), 32'd5);
        bif.branch_target = 12'd5;
        step();
        bif.branch_target = 12'h100;
        step();
        bif.branch_taken = 1'b0;
        check_eq("halt_br_done", 32'(bif.done), 32'd1);
        check_eq("halt_br_pc", 32'(bif.instr_ROM_ctr), 32'd5);
        check_eq("halt_br_cnt", 32'(bif.retired_cnt), 32'd6);

        // stall at 7, start ignored mid-run, reset mid-run at 9
        rom[5] = 9'h005;
        rom[20] = 9'h1FF;
        pulse_start();
        run_to_pc(12'd7, "reach_pc7");
        bif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_pc", 32'(bif.instr_ROM_ctr), 32'd7);
            check_eq("stall_cnt", 32'(bif.retired_cnt), 32'd7);
        end
        bif.stall = 1'b0;
        step();
        check_eq("unstall_pc", 32'(bif.instr_ROM_ctr), 32'd8);
        pulse_start();
        check_eq("start_in_run_pc", 32'(bif.instr_ROM_ctr), 32'd9);
        check_eq("start_in_run_cnt", 32'(bif.retired_cnt), 32'd9);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_eq("midrst_pc", 32'(bif.instr_ROM_ctr), 32'd0);
        check_eq("midrst_cnt", 32'(bif.retired_cnt), 32'd0);
        check_eq("midrst_running", 32'(bif.running), 32'd0);
        step();
        check_eq("midrst_idle_pc", 32'(bif.instr_ROM_ctr), 32'd0);

        // narrow instance: PC wrap and counter saturation
        step_s();
        rst_s_n = 1'b1;
        sif.start = 1'b1;
        step_s();
        sif.start = 1'b0;
        for (int i = 0; i < 20; i++) step_s();
        check_eq("s_wrap_pc", 32'(sif.instr_ROM_ctr), 32'd4);
        check_eq("s_sat_cnt", 32'(sif.retired_cnt), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
